// File: rtl/btn_cursor_ctrl.sv
// btn_cursor_ctrl: button front end for the minefield game.
// Six raw buttons go through a 2-flop synchroniser and a per-button debouncer.
// Rising edges of the debounced levels become one-cycle action pulses and
// cursor moves on a wrapping GRID_W x GRID_H grid.
// Optional macro BTN_AUTO_REPEAT_EN: held direction buttons auto-repeat.
//
// Per-button debounce state:
//   state    | meaning
//   STABLE   | synchronised input matches debounced level, counter at 0
//   COUNTING | mismatch seen, counting consecutive mismatching cycles
module btn_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int GRID_W          = 16,
    parameter int GRID_H          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       tap,
    input  logic       mark,
    input  logic       dead,
    output logic [3:0] cur_x,
    output logic [3:0] cur_y,
    output logic [7:0] cell_addr,
    output logic       tap_pulse,
    output logic       mark_pulse,
    output logic       move_pulse
);

    localparam int NB = 6;
    localparam int BL = 0;
    localparam int BR = 1;
    localparam int BU = 2;
    localparam int BD = 3;
    localparam int BT = 4;
    localparam int BM = 5;

    localparam logic [3:0]       X_MAX  = 4'(GRID_W - 1);
    localparam logic [3:0]       Y_MAX  = 4'(GRID_H - 1);
    localparam logic [CNT_W-1:0] DB_END = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, COUNTING} db_state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] level;
    logic [NB-1:0] level_d;
    logic [NB-1:0] rise_q;
    logic [3:0]    dir;
    logic [3:0]    nx;
    logic [3:0]    ny;
    logic          moved;

    assign raw = {mark, tap, down_button, up_button, right_button, left_button};

    // Two-flop synchroniser, edge-detect delay and registered rising-edge pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level_d <= '0;
            rise_q  <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            rise_q  <= level & ~level_d;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_db
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        // Debounce: level toggles only after DEBOUNCE_CYCLES consecutive mismatches
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state <= STABLE;
                cnt   <= '0;
                lvl   <= 1'b0;
            end else begin
                case (state)
                    STABLE: begin
                        if (sync2[i] != lvl) begin
                            state <= COUNTING;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    COUNTING: begin
                        if (sync2[i] == lvl) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == DB_END) begin
                            state <= STABLE;
                            cnt   <= '0;
                            lvl   <= ~lvl;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign level[i] = lvl;
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIRST = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'((1 << (CNT_W - 2)) - 1);

    logic [3:0] rep_q;

    for (genvar i = 0; i < 4; i++) begin : g_rep
        logic [CNT_W-1:0] rcnt;
        logic             armed;
        logic             rq;

        // Repeat timer: long first delay, then shorter period until debounced release
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rcnt  <= '0;
                armed <= 1'b0;
                rq    <= 1'b0;
            end else begin
                rq <= 1'b0;
                if (!level[i]) begin
                    rcnt  <= '0;
                    armed <= 1'b0;
                end else if (rcnt == (armed ? REP_NEXT : REP_FIRST)) begin
                    rq    <= 1'b1;
                    rcnt  <= '0;
                    armed <= 1'b1;
                end else begin
                    rcnt <= rcnt + CNT_W'(1);
                end
            end
        end

        assign rep_q[i] = rq;
    end

    assign dir = rise_q[BD:BL] | rep_q;
`else
    assign dir = rise_q[BD:BL];
`endif

    // Next cursor position; opposing directions in one cycle cancel
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        if (dir[BL] && !dir[BR]) begin
            nx = (cur_x == 4'd0) ? X_MAX : cur_x - 4'd1;
        end else if (dir[BR] && !dir[BL]) begin
            nx = (cur_x == X_MAX) ? 4'd0 : cur_x + 4'd1;
        end
        if (dir[BU] && !dir[BD]) begin
            ny = (cur_y == 4'd0) ? Y_MAX : cur_y - 4'd1;
        end else if (dir[BD] && !dir[BU]) begin
            ny = (cur_y == Y_MAX) ? 4'd0 : cur_y + 4'd1;
        end
    end

    // Cursor, address and action outputs; dead freezes the cursor and masks pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_x      <= '0;
            cur_y      <= '0;
            cell_addr  <= '0;
            moved      <= 1'b0;
            move_pulse <= 1'b0;
            tap_pulse  <= 1'b0;
            mark_pulse <= 1'b0;
        end else begin
            moved <= 1'b0;
            if (!dead && (nx != cur_x || ny != cur_y)) begin
                cur_x     <= nx;
                cur_y     <= ny;
                cell_addr <= {ny, nx};
                moved     <= 1'b1;
            end
            move_pulse <= moved & ~dead;
            tap_pulse  <= rise_q[BT] & ~dead;
            mark_pulse <= rise_q[BM] & ~rise_q[BT] & ~dead;
        end
    end

endmodule

// File: tb/tb_btn_cursor_ctrl.sv
// Directed bench for btn_cursor_ctrl with a short debounce window.
module tb_btn_cursor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       left_button = 1'b0;
    logic       right_button = 1'b0;
    logic       up_button = 1'b0;
    logic       down_button = 1'b0;
    logic       tap = 1'b0;
    logic       mark = 1'b0;
    logic       dead = 1'b0;
    logic [3:0] cur_x;
    logic [3:0] cur_y;
    logic [7:0] cell_addr;
    logic       tap_pulse;
    logic       mark_pulse;
    logic       move_pulse;

    int checks = 0;
    int errors = 0;

    int n_tap, n_mark, n_move;
    int first_tap, first_mark, first_move;
    int tick_idx;

    btn_cursor_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4),
        .GRID_W(16),
        .GRID_H(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .left_button(left_button),
        .right_button(right_button),
        .up_button(up_button),
        .down_button(down_button),
        .tap(tap),
        .mark(mark),
        .dead(dead),
        .cur_x(cur_x),
        .cur_y(cur_y),
        .cell_addr(cell_addr),
        .tap_pulse(tap_pulse),
        .mark_pulse(mark_pulse),
        .move_pulse(move_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_tap = 0; n_mark = 0; n_move = 0;
        first_tap = 0; first_mark = 0; first_move = 0;
        tick_idx = 0;
    endtask

    // Advance n cycles, tallying output pulses and the tick of the first of each
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            tick_idx++;
            if (tap_pulse) begin
                n_tap++;
                if (first_tap == 0) first_tap = tick_idx;
            end
            if (mark_pulse) begin
                n_mark++;
                if (first_mark == 0) first_mark = tick_idx;
            end
            if (move_pulse) begin
                n_move++;
                if (first_move == 0) first_move = tick_idx;
            end
        end
    endtask

    task automatic press(input logic l, input logic r, input logic u, input logic d,
                         input logic t, input logic m, input int hold);
        clear_counts();
        left_button = l; right_button = r; up_button = u; down_button = d;
        tap = t; mark = m;
        run(hold);
        left_button = 0; right_button = 0; up_button = 0; down_button = 0;
        tap = 0; mark = 0;
        run(14);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({cur_x, cur_y, cell_addr, tap_pulse, mark_pulse, move_pulse} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got x=%0d y=%0d addr=%h t=%b m=%b mv=%b, want all 0",
                     cur_x, cur_y, cell_addr, tap_pulse, mark_pulse, move_pulse);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cur_x, cur_y, cell_addr, move_pulse} !== 17'd0) begin
            errors++;
            $display("FAIL reset_release: got x=%0d y=%0d addr=%h mv=%b, want 0",
                     cur_x, cur_y, cell_addr, move_pulse);
        end
    endtask

    task automatic test_right_latency();
        clear_counts();
        right_button = 1'b1;
        run(7);
        checks++;
        if (cur_x !== 4'd0) begin
            errors++;
            $display("FAIL right_early: cur_x=%0d, want 0", cur_x);
        end
        run(1);
        checks++;
        if (cur_x !== 4'd1 || cell_addr !== 8'h01 || move_pulse !== 1'b0) begin
            errors++;
            $display("FAIL right_update: x=%0d addr=%h mv=%b, want 1 01 0", cur_x, cell_addr, move_pulse);
        end
        run(1);
        checks++;
        if (move_pulse !== 1'b1) begin
            errors++;
            $display("FAIL right_move_pulse: mv=%b, want 1", move_pulse);
        end
`ifndef BTN_AUTO_REPEAT_EN
        clear_counts();
        run(50);
        checks++;
        if (n_move !== 0 || cur_x !== 4'd1) begin
            errors++;
            $display("FAIL right_hold: moves=%0d x=%0d, want 0 1", n_move, cur_x);
        end
`endif
        right_button = 1'b0;
        run(14);
    endtask

    task automatic test_wrap();
        press(1, 0, 0, 0, 0, 0, 8);
        checks++;
        if (cur_x !== 4'd0 || n_move !== 1) begin
            errors++;
            $display("FAIL left_to_zero: x=%0d moves=%0d, want 0 1", cur_x, n_move);
        end
        press(1, 0, 0, 0, 0, 0, 8);
        checks++;
        if (cur_x !== 4'd15) begin
            errors++;
            $display("FAIL left_wrap: x=%0d, want 15", cur_x);
        end
        press(0, 0, 1, 0, 0, 0, 8);
        checks++;
        if (cur_y !== 4'd15 || cell_addr !== 8'hFF) begin
            errors++;
            $display("FAIL up_wrap: y=%0d addr=%h, want 15 ff", cur_y, cell_addr);
        end
        press(0, 1, 0, 0, 0, 0, 8);
        checks++;
        if (cur_x !== 4'd0 || cell_addr !== 8'hF0) begin
            errors++;
            $display("FAIL right_wrap: x=%0d addr=%h, want 0 f0", cur_x, cell_addr);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        tap = 1'b1; run(1); tap = 1'b0; run(14);
        checks++;
        if (n_tap !== 0) begin
            errors++;
            $display("FAIL glitch_1: taps=%0d, want 0", n_tap);
        end
        clear_counts();
        tap = 1'b1; run(3); tap = 1'b0; run(14);
        checks++;
        if (n_tap !== 0) begin
            errors++;
            $display("FAIL glitch_3: taps=%0d, want 0", n_tap);
        end
        press(0, 0, 0, 0, 1, 0, 4);
        checks++;
        if (n_tap !== 1 || first_tap !== 8 || n_mark !== 0) begin
            errors++;
            $display("FAIL tap_latency: taps=%0d at tick %0d marks=%0d, want 1 at 8, 0",
                     n_tap, first_tap, n_mark);
        end
    endtask

    task automatic test_same_cycle();
        press(0, 0, 0, 0, 1, 1, 8);
        checks++;
        if (n_tap !== 1 || n_mark !== 0) begin
            errors++;
            $display("FAIL tap_mark_arb: taps=%0d marks=%0d, want 1 0", n_tap, n_mark);
        end
        press(0, 0, 0, 0, 0, 1, 8);
        checks++;
        if (n_mark !== 1 || first_mark !== 8 || n_tap !== 0) begin
            errors++;
            $display("FAIL mark_alone: marks=%0d at %0d taps=%0d, want 1 at 8, 0",
                     n_mark, first_mark, n_tap);
        end
        press(1, 1, 0, 0, 0, 0, 8);
        checks++;
        if (cur_x !== 4'd0 || n_move !== 0) begin
            errors++;
            $display("FAIL left_right_cancel: x=%0d moves=%0d, want 0 0", cur_x, n_move);
        end
        press(0, 1, 0, 1, 0, 0, 8);
        checks++;
        if (cur_x !== 4'd1 || cur_y !== 4'd0 || cell_addr !== 8'h01 || n_move !== 1) begin
            errors++;
            $display("FAIL diag_move: x=%0d y=%0d addr=%h moves=%0d, want 1 0 01 1",
                     cur_x, cur_y, cell_addr, n_move);
        end
    endtask

    task automatic test_dead();
        clear_counts();
        dead = 1'b1;
        tap = 1'b1; mark = 1'b1; down_button = 1'b1;
        run(12);
        mark = 1'b0; down_button = 1'b0;
        run(12);
        checks++;
        if (n_tap !== 0 || n_mark !== 0 || n_move !== 0 || cur_x !== 4'd1 || cur_y !== 4'd0) begin
            errors++;
            $display("FAIL dead_mask: t=%0d m=%0d mv=%0d x=%0d y=%0d, want 0 0 0 1 0",
                     n_tap, n_mark, n_move, cur_x, cur_y);
        end
        clear_counts();
        dead = 1'b0;
        run(12);
        checks++;
        if (n_tap !== 0) begin
            errors++;
            $display("FAIL dead_held_tap: taps=%0d, want 0", n_tap);
        end
        tap = 1'b0;
        run(14);
        press(0, 0, 0, 0, 1, 0, 8);
        checks++;
        if (n_tap !== 1 || first_tap !== 8) begin
            errors++;
            $display("FAIL dead_repress: taps=%0d at %0d, want 1 at 8", n_tap, first_tap);
        end
    endtask

    task automatic test_reset_mid_debounce();
        up_button = 1'b1;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (cur_x !== 4'd0 || cur_y !== 4'd0 || cell_addr !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_clear: x=%0d y=%0d addr=%h, want 0 0 00", cur_x, cur_y, cell_addr);
        end
        rst_n = 1'b1;
        clear_counts();
        run(7);
        checks++;
        if (cur_y !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_early: y=%0d, want 0", cur_y);
        end
        run(1);
        checks++;
        if (cur_y !== 4'd15 || cell_addr !== 8'hF0) begin
            errors++;
            $display("FAIL mid_reset_full_window: y=%0d addr=%h, want 15 f0", cur_y, cell_addr);
        end
        up_button = 1'b0;
        run(14);
    endtask

`ifdef BTN_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int times[$];
        clear_counts();
        right_button = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (move_pulse) times.push_back(k);
        end
        right_button = 1'b0;
        run(30);
        checks++;
        if (times.size() < 4) begin
            errors++;
            $display("FAIL repeat_count: moves=%0d, want at least 4", times.size());
        end else if (times[0] != 9 || times[1] != 24 || times[2] != 28 || times[3] != 32) begin
            errors++;
            $display("FAIL repeat_timing: ticks %0d %0d %0d %0d, want 9 24 28 32",
                     times[0], times[1], times[2], times[3]);
        end
    endtask
`endif

    initial begin
        clear_counts();
        test_reset();
        test_right_latency();
        test_wrap();
        test_glitch();
        test_same_cycle();
        test_dead();
        test_reset_mid_debounce();
`ifdef BTN_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
